// File: rtl/ddr_fb_pkg.sv
// Shared types and helpers for the camera frame-buffer DDR write path.
package ddr_fb_pkg;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  localparam int unsigned BYTES_PER_BEAT  = 16;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [27:0] BANK0_BASE_DFLT = 28'h0000000;
  localparam logic [27:0] BANK1_BASE_DFLT = 28'h0200000;

  // awlen of the next burst, clipped so a burst never runs past the frame end
  function automatic logic [7:0] calc_awlen(int unsigned remaining, int unsigned burst_len);
    int unsigned beats;
    beats = (remaining < burst_len) ? remaining : burst_len;
    return 8'(beats - 32'd1);
  endfunction

  function automatic int unsigned burst_bytes(logic [7:0] awlen);
    return (32'(awlen) + 32'd1) * BYTES_PER_BEAT;
  endfunction

endpackage

// File: rtl/ddr_wr_burst_ctrl_if.sv
// Prefetch-FIFO read side plus AXI write channels of the frame-buffer writer.
interface ddr_wr_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
);

  logic                    fifo_rd_vld;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_rd_en;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    input  fifo_rd_vld, fifo_rd_data, awready, wready, bvalid, bresp,
    output fifo_rd_en, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output fifo_rd_vld, fifo_rd_data, awready, wready, bvalid, bresp,
    input  fifo_rd_en, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready
  );

endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the camera prefetch FIFO into ping-pong DDR frame buffers as AXI INCR write bursts,
// one outstanding burst at a time.
module ddr_wr_burst_ctrl
  import ddr_fb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 28,
  parameter int unsigned           DATA_WIDTH  = 128,
  parameter int unsigned           BURST_LEN   = 16,
  parameter int unsigned           FRAME_WORDS = 115200,
  parameter logic [ADDR_WIDTH-1:0] BANK0_BASE  = ADDR_WIDTH'(BANK0_BASE_DFLT),
  parameter logic [ADDR_WIDTH-1:0] BANK1_BASE  = ADDR_WIDTH'(BANK1_BASE_DFLT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  ddr_wr_burst_ctrl_if.master bus,
  output logic                wr_bank,
  output logic                frame_done,
  output logic                frame_err,
  output logic                resp_err
);

  localparam int unsigned CNT_WIDTH = $clog2(FRAME_WORDS + 1);

  // Bursts may never straddle a 4KB page
  if (BURST_LEN < 1 || BURST_LEN > 256 || DATA_WIDTH / 8 != BYTES_PER_BEAT ||
      (4096 % (BURST_LEN * BYTES_PER_BEAT)) != 0 ||
      BANK0_BASE[11:0] != 12'd0 || BANK1_BASE[11:0] != 12'd0) begin : g_cfg_err
    $error("ddr_wr_burst_ctrl: burst/base configuration can cross a 4KB boundary");
  end

  state_e                state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic [7:0]            beat_idx, beat_idx_d;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_d;
  logic                  wr_bank_d, frame_done_d, frame_err_d, resp_err_d;
  logic                  start_pend, start_pend_d;
  logic                  w_hs_c, frame_full_c;

  function automatic logic [ADDR_WIDTH-1:0] bank_base(logic bank);
    return bank ? BANK1_BASE : BANK0_BASE;
  endfunction

  // W channel is a straight pass-through of the FIFO head
  assign bus.wvalid     = (state == ST_W) && bus.fifo_rd_vld;
  assign w_hs_c         = bus.wvalid && bus.wready;
  assign bus.fifo_rd_en = w_hs_c;
  assign bus.wdata      = bus.fifo_rd_data;
  assign bus.wstrb      = {(DATA_WIDTH/8){1'b1}};
  assign bus.wlast      = (state == ST_W) && (beat_idx == awlen_q);
  assign bus.awaddr     = addr;
  assign bus.awlen      = awlen_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.bready     = bready_q;
  assign frame_full_c   = (beat_cnt == CNT_WIDTH'(FRAME_WORDS));

  always_comb begin
    state_d      = state;
    addr_d       = addr;
    awlen_d      = awlen_q;
    awvalid_d    = awvalid_q;
    bready_d     = bready_q;
    beat_idx_d   = beat_idx;
    beat_cnt_d   = beat_cnt;
    wr_bank_d    = wr_bank;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    resp_err_d   = resp_err;
    start_pend_d = start_pend | frame_start;
    case (state)
      ST_HALT: begin
        start_pend_d = 1'b0;
        if (frame_start || start_pend) begin
          if (frame_full_c) begin
            wr_bank_d = ~wr_bank;
          end
          beat_cnt_d = '0;
          addr_d     = bank_base(wr_bank_d);
          state_d    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A frame_start seen mid-frame restarts the same bank from its base
        if (start_pend) begin
          frame_err_d  = 1'b1;
          start_pend_d = frame_start;
          beat_cnt_d   = '0;
          addr_d       = bank_base(wr_bank);
          awlen_d      = calc_awlen(FRAME_WORDS, BURST_LEN);
          awvalid_d    = 1'b1;
          beat_idx_d   = '0;
          state_d      = ST_AW;
        end else if (frame_full_c) begin
          frame_done_d = 1'b1;
          state_d      = ST_HALT;
        end else begin
          awlen_d    = calc_awlen(FRAME_WORDS - 32'(beat_cnt), BURST_LEN);
          awvalid_d  = 1'b1;
          beat_idx_d = '0;
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        if (bus.awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (w_hs_c) begin
          if (beat_idx == awlen_q) begin
            addr_d     = addr + ADDR_WIDTH'(burst_bytes(awlen_q));
            beat_cnt_d = beat_cnt + CNT_WIDTH'(32'(awlen_q) + 32'd1);
            bready_d   = 1'b1;
            state_d    = ST_B;
          end else begin
            beat_idx_d = beat_idx + 8'd1;
          end
        end
      end
      ST_B: begin
        if (bus.bvalid) begin
          bready_d = 1'b0;
          if (bus.bresp != AXI_RESP_OKAY) begin
            resp_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_HALT;
      addr       <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      beat_idx   <= '0;
      beat_cnt   <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      resp_err   <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      bready_q   <= bready_d;
      beat_idx   <= beat_idx_d;
      beat_cnt   <= beat_cnt_d;
      wr_bank    <= wr_bank_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
      resp_err   <= resp_err_d;
      start_pend <= start_pend_d;
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Scoreboard bench for ddr_wr_burst_ctrl with a 40-beat frame and 16-beat bursts.
module tb_ddr_wr_burst_ctrl;
  import ddr_fb_pkg::*;

  localparam int unsigned    AW = 28;
  localparam int unsigned    DW = 128;
  localparam int unsigned    BL = 16;
  localparam int unsigned    FW = 40;
  localparam logic [AW-1:0]  B0 = 28'h0000000;
  localparam logic [AW-1:0]  B1 = 28'h0200000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic wr_bank, frame_done, frame_err, resp_err;

  ddr_wr_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr_wr_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FRAME_WORDS(FW),
    .BANK0_BASE(B0), .BANK1_BASE(B1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bus(bus),
    .wr_bank(wr_bank), .frame_done(frame_done), .frame_err(frame_err), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  aw_exp_t     exp_aw[$];
  logic [DW-1:0] exp_w[$];
  int unsigned seq       = 0;
  int unsigned pop_total = 0;
  logic        vld_toggle = 1'b0;
  logic        rand_ready = 1'b0;
  logic [1:0]  resp_code  = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0]  cur_len = 8'd0;
  int          beat_no = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] word(int unsigned s);
    return {s, ~s, s ^ 32'hA5A5_A5A5, 32'hC0DE_0000 + s};
  endfunction

  // FIFO + AXI slave: a new head word enters the scoreboard when it is presented
  initial begin
    bus.fifo_rd_vld  = 1'b1;
    bus.fifo_rd_data = word(0);
    exp_w.push_back(word(0));
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (pop_total != seq) begin
        seq++;
        bus.fifo_rd_data = word(seq);
        exp_w.push_back(word(seq));
      end
      bus.fifo_rd_vld = vld_toggle ? ~bus.fifo_rd_vld : 1'b1;
      bus.awready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bvalid      = bus.bready;
      bus.bresp       = resp_code;
    end
  end

  // Handshakes sampled at negedge are the ones taken on the following posedge
  always @(negedge clk) begin : mon
    aw_exp_t e;
    check("rd_en_eq_hs", DW'(bus.fifo_rd_en), DW'(bus.wvalid & bus.wready));
    check("wvalid_no_data", DW'(bus.wvalid & ~bus.fifo_rd_vld), DW'(0));
    if (bus.awvalid && bus.awready) begin
      aw_cnt++;
      check("aw_expected", DW'(exp_aw.size() != 0), DW'(1));
      if (exp_aw.size() != 0) begin
        e = exp_aw.pop_front();
        check("awaddr", DW'(bus.awaddr), DW'(e.addr));
        check("awlen", DW'(bus.awlen), DW'(e.len));
        cur_len = e.len;
        beat_no = 0;
      end
    end
    if (bus.fifo_rd_en) pop_total++;
    if (bus.wvalid && bus.wready) begin
      w_cnt++;
      check("w_expected", DW'(exp_w.size() != 0), DW'(1));
      if (exp_w.size() != 0) check("wdata", bus.wdata, exp_w.pop_front());
      check("wlast", DW'(bus.wlast), DW'(beat_no == int'(cur_len)));
      beat_no++;
    end
    if (bus.bvalid && bus.bready) b_cnt++;
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic push_frame(input logic [AW-1:0] base);
    aw_exp_t       e;
    int unsigned   rem = FW;
    int unsigned   n;
    logic [AW-1:0] a = base;
    while (rem > 0) begin
      n = (rem < BL) ? rem : BL;
      e.addr = a;
      e.len  = 8'(n - 1);
      exp_aw.push_back(e);
      a   = a + AW'(n * 16);
      rem = rem - n;
    end
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, DW'(done_cnt >= target), DW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int t;
    int d0, a0, b0, w0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", DW'(bus.awvalid), DW'(0));
    check("rst_wvalid", DW'(bus.wvalid), DW'(0));
    check("rst_bready", DW'(bus.bready), DW'(0));
    check("rst_rd_en", DW'(bus.fifo_rd_en), DW'(0));
    check("rst_wlast", DW'(bus.wlast), DW'(0));
    check("rst_awaddr", DW'(bus.awaddr), DW'(0));
    check("rst_wstrb", DW'(bus.wstrb), DW'(16'hFFFF));
    check("rst_flags", DW'({wr_bank, frame_done, frame_err, resp_err}), DW'(0));
    rst_n = 1'b1;

    // Frame 1: bank 0, bursts 15/15/7
    push_frame(B0);
    start_frame();
    wait_done(1, "t1_done");
    check("t1_b_cnt", DW'(b_cnt), DW'(3));
    check("t1_aw_left", DW'(exp_aw.size()), DW'(0));
    check("t1_bank", DW'(wr_bank), DW'(0));

    // Frames 2 and 3: ping-pong, frame 3 with a stuttering FIFO and random ready
    push_frame(B1);
    start_frame();
    wait_done(2, "t2_done");
    check("t2_bank", DW'(wr_bank), DW'(1));
    vld_toggle = 1'b1;
    rand_ready = 1'b1;
    push_frame(B0);
    start_frame();
    wait_done(3, "t3_done");
    vld_toggle = 1'b0;
    rand_ready = 1'b0;
    check("t3_bank", DW'(wr_bank), DW'(0));
    check("t3_beats", DW'(w_cnt), DW'(3 * FW));

    // Frame 4: restart mid-frame on the same bank
    push_frame(B1);
    push_frame(B1);
    a0 = aw_cnt;
    d0 = done_cnt;
    start_frame();
    t = 0;
    while (aw_cnt < a0 + 3 && t < 1000) begin @(negedge clk); t++; end
    check("t4_third_aw", DW'(aw_cnt >= a0 + 3), DW'(1));
    start_frame();
    t = 0;
    while (err_cnt < 1 && t < 1000) begin @(negedge clk); t++; end
    check("t4_err", DW'(err_cnt), DW'(1));
    check("t4_no_done", DW'(done_cnt), DW'(d0));
    wait_done(d0 + 1, "t4_done");
    check("t4_bank", DW'(wr_bank), DW'(1));
    check("t4_aw_left", DW'(exp_aw.size()), DW'(0));
    check("t4_err_once", DW'(err_cnt), DW'(1));

    // Frame 5: SLVERR on the first response is sticky
    check("t5_resp_pre", DW'(resp_err), DW'(0));
    push_frame(B0);
    resp_code = 2'b10;
    b0 = b_cnt;
    d0 = done_cnt;
    start_frame();
    t = 0;
    while (b_cnt == b0 && t < 1000) begin @(negedge clk); t++; end
    resp_code = 2'b00;
    @(posedge clk);
    #1;
    check("t5_resp_set", DW'(resp_err), DW'(1));
    wait_done(d0 + 1, "t5_done");
    check("t5_resp_sticky", DW'(resp_err), DW'(1));
    check("t5_bank", DW'(wr_bank), DW'(0));

    // Frame 6: reset while bursting
    push_frame(B1);
    w0 = w_cnt;
    start_frame();
    t = 0;
    while (w_cnt < w0 + 5 && t < 1000) begin @(negedge clk); t++; end
    check("t6_bank_pre", DW'(wr_bank), DW'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_awvalid", DW'(bus.awvalid), DW'(0));
    check("t6_wvalid", DW'(bus.wvalid), DW'(0));
    check("t6_bready", DW'(bus.bready), DW'(0));
    check("t6_rd_en", DW'(bus.fifo_rd_en), DW'(0));
    check("t6_bank", DW'(wr_bank), DW'(0));
    check("t6_resp_clr", DW'(resp_err), DW'(0));
    rst_n = 1'b1;
    exp_aw.delete();

    // Frame 7: first frame after reset stays on bank 0
    push_frame(B0);
    d0 = done_cnt;
    start_frame();
    wait_done(d0 + 1, "t7_done");
    check("t7_bank", DW'(wr_bank), DW'(0));
    check("t7_aw_left", DW'(exp_aw.size()), DW'(0));

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
